// File: rtl/tx_pkg.sv
// tx_pkg: shared FSM state type and timing constants for the tx block.
package tx_pkg;
  typedef enum logic [1:0] {IDLE, SOC, DATA, EOC} state_t;
  localparam int BIT_PERIOD = 128;
  localparam int SUBCARRIER_PERIOD = 16;
  localparam int BIT_W = $clog2(BIT_PERIOD);
  localparam int SC_W = $clog2(SUBCARRIER_PERIOD);
endpackage

// File: rtl/tx_interface.sv
// tx_interface: source-to-tx handshake; data_valid/data from source, req pulse back to source.
interface tx_interface #(parameter bit BY_BYTE = 1'b0);
  localparam int W = BY_BYTE ? 8 : 1;
  logic data_valid;
  logic [W-1:0] data;
  logic req;
  modport sink (input data_valid, input data, output req);
  modport source (output data_valid, output data, input req);
endinterface

// File: rtl/tx_subcarrier_gen.sv
// subcarrier_gen: fc/16 square wave (8 high, 8 low, starting high); ports clk, rst_n, restart, sc_next.
// sc_next is the subcarrier level for the coming cycle so the caller can register it without lag.
module subcarrier_gen
  import tx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic sc_next
);
  logic [SC_W-1:0] cnt, cnt_nxt;
  always_comb cnt_nxt = restart ? '0 : cnt + 1'b1;
  assign sc_next = ~cnt_nxt[SC_W-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= cnt_nxt;
endmodule

// File: rtl/tx.sv
// tx: Manchester/subcarrier frame transmitter; ports clk, rst_n, in_iface (bit-serial sink), tx_out (load modulator drive).
module tx
  import tx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  tx_interface.sink in_iface,
  output logic tx_out
);
  state_t state, state_nxt;
  logic [BIT_W-1:0] cnt, cnt_nxt;
  logic bit_q, bit_nxt, req_q, req_nxt, boundary, enc, mod_nxt, sc_next;
  assign in_iface.req = req_q;
  subcarrier_gen u_sc (.clk(clk), .rst_n(rst_n), .restart(state == IDLE), .sc_next(sc_next));
  // tx_out is registered, so modulation is computed from next-cycle state and counters.
  always_comb begin
    boundary = (state != IDLE) && (cnt == BIT_W'(BIT_PERIOD - 1));
    cnt_nxt = (state == IDLE) ? '0 : cnt + 1'b1;
    req_nxt = boundary && (state != EOC) && in_iface.data_valid;
    bit_nxt = req_nxt ? in_iface.data[0] : bit_q;
    state_nxt = state;
    case (state)
      IDLE: state_nxt = in_iface.data_valid ? SOC : IDLE;
      SOC, DATA: state_nxt = boundary ? (req_nxt ? DATA : EOC) : state;
      EOC: state_nxt = boundary ? IDLE : EOC;
      default: state_nxt = IDLE;
    endcase
    // enc=1 modulates the first half-bit, enc=0 the second; SOC encodes a '1'.
    enc = (state_nxt == SOC) || bit_nxt;
    mod_nxt = (state_nxt == SOC || state_nxt == DATA) && (cnt_nxt[BIT_W-1] ^ enc);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_q <= 1'b0;
      req_q <= 1'b0;
      tx_out <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      bit_q <= bit_nxt;
      req_q <= req_nxt;
      tx_out <= sc_next && mod_nxt;
    end
endmodule

// File: tb/tb_tx.sv
// tb_tx: directed self-checking bench for tx with a cycle-exact waveform model.
module tb_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lm;
  int n_assert = 0;
  int n_fail = 0;
  logic [127:0] b;
  tx_interface #(.BY_BYTE(1'b0)) ifc ();
  tx dut (.clk(clk), .rst_n(rst_n), .in_iface(ifc), .tx_out(lm));
  always #5 clk = ~clk;

  task automatic check(input string tag, input int id, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s frame %0d: observed %b expected %b at %0t", tag, id, obs, exp, $time);
    end
  endtask

  task automatic idle(input int k, input int id);
    ifc.data_valid = 1'b0;
    ifc.data = 1'b0;
    repeat (k) begin
      @(negedge clk);
      check("idle_tx_out", id, lm, 1'b0);
      check("idle_req", id, ifc.req, 1'b0);
    end
  endtask

  // Drives one frame and checks every cycle from SOC start to EOC end.
  // gap: posedges until the SOC-entry edge; rd: source response phase after req;
  // hold: raise data_valid during EOC to queue the next frame.
  task automatic run_frame(input logic [127:0] bits, input int n, input bit hold,
                           input int gap, input int rd, input int id);
    int p, ph;
    logic enc, exp_out, exp_req;
    ifc.data_valid = 1'b1;
    ifc.data = bits[0];
    repeat (gap) @(posedge clk);
    for (int c = 0; c < (n + 2) * 128; c++) begin
      @(negedge clk);
      p = c / 128;
      ph = c % 128;
      if (p == 0) enc = 1'b1;
      else if (p <= n) enc = bits[p-1];
      else enc = 1'b0;
      exp_out = (p <= n) && (enc ? (ph < 64) : (ph >= 64)) && ((ph % 16) < 8);
      exp_req = (ph == 0) && (p >= 1) && (p <= n);
      check("tx_out", id, lm, exp_out);
      check("req", id, ifc.req, exp_req);
      if (ph == rd) begin
        ifc.data_valid = (p < n) || (hold && p == n + 1);
        ifc.data = (p < n) ? bits[p] : 1'b0;
      end
    end
  endtask

  initial begin
    ifc.data_valid = 1'b0;
    ifc.data = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("rst_tx_out", 0, lm, 1'b0);
      check("rst_req", 0, ifc.req, 1'b0);
    end
    rst_n = 1'b1;
    idle(512, 0);
    run_frame(128'b1, 1, 1'b0, 1, 20, 1);
    idle(3, 1);
    run_frame(128'b0, 1, 1'b0, 1, 20, 2);
    idle(3, 2);
    run_frame(128'b0, 0, 1'b0, 1, 20, 3);
    idle(3, 3);
    run_frame(128'b1101_0010, 8, 1'b0, 1, 127, 4);
    idle(3, 4);
    run_frame(128'b0110, 4, 1'b1, 1, 8, 5);
    run_frame(128'b1001, 4, 1'b0, 2, 64, 6);
    idle(3, 6);
    ifc.data_valid = 1'b1;
    ifc.data = 1'b1;
    @(posedge clk);
    repeat (129) @(negedge clk);
    check("pre_rst_tx_out", 7, lm, 1'b1);
    check("pre_rst_req", 7, ifc.req, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_tx_out", 7, lm, 1'b0);
    check("async_rst_req", 7, ifc.req, 1'b0);
    ifc.data_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(10, 7);
    run_frame(128'b1011, 4, 1'b0, 1, 30, 8);
    for (int f = 0; f < 8; f++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      idle(3, 20 + f);
      run_frame(b, int'($urandom_range(1, 20)), 1'b0, 1, int'($urandom_range(8, 127)), 20 + f);
    end
    idle(20, 99);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/tx.md
TX -- requirements
Module: tx

Interface
REQ-001 Parameters: none; timing constants come from the shared package (REQ-024).
REQ-002 clk  input  1  system clock; nominal fc = 13.56 MHz; all timing is counted in clk cycles.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 in_iface  interface  -  tx_interface instance with BY_BYTE=0 (bit-serial source); it carries REQ-005 to REQ-007.
REQ-005 in_iface.data_valid  input  1  high while the source has a bit to send; low ends the frame.
REQ-006 in_iface.data  input  1  current bit to send.
REQ-007 in_iface.req  output  1  one-cycle pulse: current bit consumed, source shall present next bit or drop data_valid.
REQ-008 tx_out  output  1  load-modulator drive, Manchester data ANDed with subcarrier; 0 = no modulation.

Function
REQ-009 Timing constants: bit period 128 cycles; half-bit 64 cycles; subcarrier fc/16, i.e. 8 cycles high then 8 cycles low, starting high.
REQ-010 States shall be IDLE, SOC, DATA and EOC.
REQ-011 IDLE: tx_out=0 and req=0; data_valid=1 sampled on a clk edge shall enter SOC on that edge.
REQ-012 Subcarrier and bit counters shall restart at SOC entry, so the first tx_out-high cycle is the first SOC cycle.
REQ-013 SOC: one bit period encoding logic '1'; data and data_valid are not consumed.
REQ-014 Logic '1' encoding: subcarrier during cycles 0-63 of the bit (4 pulses of 8 high/8 low); tx_out=0 during cycles 64-127.
REQ-015 Logic '0' encoding: tx_out=0 during cycles 0-63; subcarrier during cycles 64-127.
REQ-016 At each bit boundary (end of SOC or end of a DATA bit), if data_valid=1:
  - latch data as the next bit and enter or stay in DATA;
  - pulse req high for exactly that cycle.
REQ-017 At a bit boundary with data_valid=0: enter EOC; req stays 0.
REQ-018 The source shall update data or data_valid within 127 cycles after req; tx samples only at bit boundaries, so the value present at the boundary is used.
REQ-019 EOC: tx_out=0 for one bit period (128 cycles), then IDLE; data_valid is ignored during EOC.
REQ-020 Frame duration for N data bits is (N+2)*128 cycles, counting SOC and EOC; N=0 is legal and sends SOC then EOC.
REQ-021 tx_out shall be a registered output, glitch-free; it is never high outside SOC/DATA.

Reset
REQ-022 rst_n low shall immediately force:
  - state to IDLE;
  - tx_out=0, req=0;
  - all counters and the latched bit to 0.
REQ-023 Reset mid-frame shall abort the frame with no EOC; after rst_n rises, a new frame starts only from IDLE per REQ-011.

Structure
REQ-024 A shared package shall hold:
  - the state enum typedef;
  - BIT_PERIOD=128 and SUBCARRIER_PERIOD=16;
  - counter-width constants derived via $clog2.
REQ-025 One sub-module, subcarrier_gen, shall produce the fc/16 square wave with a synchronous restart input; tx contains the FSM, bit counter and Manchester gating.
REQ-026 The bench connects tx_out to load_modulator_iface.lm and clk/rst_n from clock_source; tx itself shall contain no simulation-only constructs.

Verification
REQ-027 Reset 5 cycles, data_valid=0 for 512 cycles -> tx_out=0 and req=0 throughout; monitor idle with no frames.
REQ-028 Single bit '1' -> cycles 0-63 8hi/8lo x4, 64-127 low (SOC); 128-191 subcarrier, 192-255 low; 256-383 low (EOC); one req pulse at cycle 128.
REQ-029 Single bit '0' -> SOC as above; cycles 128-191 low, 192-255 subcarrier; then EOC 128 low cycles.
REQ-030 100 random frames of 1-100 random bits, with source response 8-127 cycles after req -> the monitor decodes exactly the sent bits, SOC stripped, one frame each; each frame idle within (N+4)*128 cycles.
REQ-031 data_valid held high across the frame end (new frame queued) -> at least 128 cycles of tx_out=0 (EOC) separate the frames; both frames decode correctly.
REQ-032 rst_n pulsed low mid-DATA -> tx_out and req are 0 asynchronously; after release, the next frame is sent correctly.
